// File: rtl/fetch_pkg.sv
// Shared entry type, reset PC and pointer helper for the fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_AWIDTH = 32;
  localparam int unsigned FQ_DWIDTH = 32;
  localparam logic [31:0] FQ_RESET_PC = 32'h0100_0000;

  typedef struct packed {
    logic [FQ_AWIDTH-1:0] pc;
    logic [FQ_DWIDTH-1:0] insn;
  } fq_entry_t;

  function automatic int unsigned fq_ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry circular buffer of {pc, insn}; head visible the cycle after a push.
// Flush clears pointers and count; the storage array itself is never reset.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fq_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  entry_t                     push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = PW'(fq_ptr_next(32'(wr_ptr_q), DEPTH));
      if (do_pop)  rd_ptr_d = PW'(fq_ptr_next(32'(rd_ptr_q), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; only entries behind a valid count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// PC sequencer + DEPTH-entry {pc,insn} queue to decode; 2-cycle fetch-to-decode, 1 with FETCH_QUEUE_BYPASS_EN.
// dq_ready_i low lets the queue fill; issue stalls once queued plus in-flight entries reach DEPTH.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 32,
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(FQ_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [AWIDTH-1:0]          imem_addr_o,
  input  logic [DWIDTH-1:0]          imem_rdata_i,
  output logic                       dq_valid_o,
  input  logic                       dq_ready_i,
  output logic [AWIDTH-1:0]          dq_pc_o,
  output logic [DWIDTH-1:0]          dq_insn_o,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;

  logic              flush;
  logic              issue;
  logic              rsp_vld;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       reserved;
  entry_t            rsp_ent;
  entry_t            head;

  assign flush = rst || redirect_i;

  // Every in-flight request already owns a queue slot, so the queue can never overflow.
  assign reserved = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue    = !rst && !redirect_i && (reserved < DEPTH_W);

  assign rsp_vld      = inflight_q && !flush;
  assign rsp_ent.pc   = tag_q;
  assign rsp_ent.insn = imem_rdata_i;
  assign fifo_empty   = (fifo_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_vld && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_vld && !(bypass && dq_ready_i);
  assign pop  = !rst && !fifo_empty && dq_ready_i;

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (rsp_ent),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (issue) begin
      pc_d  = pc_q + AWIDTH'(4);
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Head outputs are zero whenever nothing valid is presented, including during reset.
  always_comb begin
    dq_valid_o = 1'b0;
    dq_pc_o    = '0;
    dq_insn_o  = '0;
    if (!rst) begin
      if (bypass) begin
        dq_valid_o = 1'b1;
        dq_pc_o    = rsp_ent.pc;
        dq_insn_o  = rsp_ent.insn;
      end else if (!fifo_empty) begin
        dq_valid_o = 1'b1;
        dq_pc_o    = head.pc;
        dq_insn_o  = head.insn;
      end
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign count_o     = fifo_count;

endmodule
